msg_schedule_expander: RTL

- Sequential SHA-256 message-schedule generator that sits directly upstream of the combinational compression hasher.
- Accepts one 512-bit padded block over a valid/ready handshake.
- Expands the block into W[0:63], one word per cycle (two per cycle when the optional feature is compiled in).
- Presents the full registered schedule array on a valid/ready output handshake, feeding the hasher's message_schedule input.

---
 rtl/msg_schedule_expander.sv | 64 ++++++
 1 files changed

// File: rtl/msg_schedule_expander.sv
// msg_schedule_expander: SHA-256 message schedule W[0..63] from one 512-bit block over valid/ready.
// Define MSG_SCHED_DUAL_EN to produce two schedule words per EXPAND cycle.
module msg_schedule_expander (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:511]     block_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:63][0:31] message_schedule,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;
  state_t state_q, state_d;
  logic [6:0] t_q, t_d;
  logic [0:63][31:0] w_q, w_d;
  logic [5:0] i;
  function automatic logic [31:0] s0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction
  function automatic logic [31:0] s1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction
  always_comb begin
    state_d = state_q;
    t_d = t_q;
    w_d = w_q;
    i = t_q[5:0];
    if (state_q == IDLE && in_valid) begin
      w_d[0:15] = block_in;
      t_d = 7'd16;
      state_d = EXPAND;
    end else if (state_q == EXPAND) begin
`ifdef MSG_SCHED_DUAL_EN
      w_d[i] = s1(w_q[i - 6'd2]) + w_q[i - 6'd7] + s0(w_q[i - 6'd15]) + w_q[i - 6'd16];
      w_d[i + 6'd1] = s1(w_q[i - 6'd1]) + w_q[i - 6'd6] + s0(w_q[i - 6'd14]) + w_q[i - 6'd15];
      t_d = t_q + 7'd2;
      state_d = (t_q == 7'd62) ? DONE : EXPAND;
`else
      w_d[i] = s1(w_q[i - 6'd2]) + w_q[i - 6'd7] + s0(w_q[i - 6'd15]) + w_q[i - 6'd16];
      t_d = t_q + 7'd1;
      state_d = (t_q == 7'd63) ? DONE : EXPAND;
`endif
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      t_q <= '0;
      w_q <= '0;
    end else begin
      state_q <= state_d;
      t_q <= t_d;
      w_q <= w_d;
    end
  end
  assign in_ready = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy = (state_q == EXPAND);
  assign message_schedule = w_q;
endmodule
